// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-driven ALU controller: default widths,
// the controller state encoding and the accepted ALU opcodes.
package uart_alu_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int OP_BITS_DEF   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_timeout.sv
// Inactivity counter: counts while enabled, restarts on clear, and flags
// expiry in the cycle the count reaches CYCLES-1.
module uart_alu_timeout #(
    parameter int CYCLES = 5_208_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear || !i_enable) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = i_enable && !i_clear && (count_q == CW'(CYCLES - 1));

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and an opcode from a UART receiver, runs the
// ALU and hands the result to a UART transmitter. Optional mid-frame timeout
// is built when UART_ALU_CTRL_TIMEOUT_EN is defined.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DATA_BITS      = DATA_BITS_DEF,
    parameter int OP_BITS        = OP_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 5_208_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [DATA_BITS-1:0] i_rx_data,
    input  logic                 i_tx_done,
    input  logic [DATA_BITS-1:0] i_alu_result,
    output logic [DATA_BITS-1:0] o_alu_a,
    output logic [DATA_BITS-1:0] o_alu_b,
    output logic [OP_BITS-1:0]   o_alu_op,
    output logic                 o_tx_start,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_error
);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
    logic [OP_BITS-1:0]   op_q, op_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic                 op_valid;
    logic                 timeout_expired;

    always_comb begin
        case (op_q)
            OP_BITS'(OP_ADD), OP_BITS'(OP_SUB), OP_BITS'(OP_AND), OP_BITS'(OP_OR),
            OP_BITS'(OP_XOR), OP_BITS'(OP_NOR), OP_BITS'(OP_SRA), OP_BITS'(OP_SRL):
                op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    logic timeout_en;
    assign timeout_en = (state_q == ST_GET_B) || (state_q == ST_GET_OP);

    uart_alu_timeout #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_rx_done),
        .i_enable (timeout_en),
        .o_expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = ST_GET_OP;
                end else if (timeout_expired) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GET_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[OP_BITS-1:0];
                    state_d = ST_EXEC;
                end else if (timeout_expired) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // A word arriving here is an overrun; it never alters the result path.
                if (op_valid) begin
                    tx_data_d  = i_alu_result;
                    tx_start_d = 1'b1;
                    state_d    = ST_SEND;
                    error_d    = i_rx_done;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                error_d = i_rx_done;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                error_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign o_alu_a    = a_q;
    assign o_alu_b    = b_q;
    assign o_alu_op   = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_error    = error_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a behavioural ALU on i_alu_result.
module tb_uart_alu_ctrl;

    localparam int DW = 8;
    localparam int OW = 6;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_rx_done = 1'b0;
    logic [DW-1:0] i_rx_data = '0;
    logic          i_tx_done = 1'b0;
    logic [DW-1:0] i_alu_result;
    logic [DW-1:0] o_alu_a, o_alu_b, o_tx_data;
    logic [OW-1:0] o_alu_op;
    logic          o_tx_start, o_busy, o_error;

    int checks = 0;
    int errors = 0;

    uart_alu_ctrl #(
        .DATA_BITS(DW),
        .OP_BITS(OW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_tx_done   (i_tx_done),
        .i_alu_result(i_alu_result),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_error     (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural ALU driven by the controller's operand/opcode registers.
    always_comb begin
        case (o_alu_op)
            6'h20:   i_alu_result = o_alu_a + o_alu_b;
            6'h22:   i_alu_result = o_alu_a - o_alu_b;
            6'h24:   i_alu_result = o_alu_a & o_alu_b;
            6'h25:   i_alu_result = o_alu_a | o_alu_b;
            6'h26:   i_alu_result = o_alu_a ^ o_alu_b;
            6'h27:   i_alu_result = ~(o_alu_a | o_alu_b);
            6'h03:   i_alu_result = $unsigned($signed(o_alu_a) >>> o_alu_b);
            6'h02:   i_alu_result = o_alu_a >> o_alu_b;
            default: i_alu_result = 8'hFF;
        endcase
    end

    task automatic send_word(input logic [DW-1:0] d);
        @(negedge i_clk);
        i_rx_done = 1'b1;
        i_rx_data = d;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_rx_data = '0;
    endtask

    task automatic pulse_tx_done();
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Sends a whole frame, checks result latency/value, then completes the transmit.
    task automatic run_frame(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] op, input logic [DW-1:0] exp);
        send_word(a);
        send_word(b);
        send_word(op);
        checks++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s exec_cycle: tx_start=%b busy=%b, required tx_start=0 busy=1", name, o_tx_start, o_busy);
        end
        @(negedge i_clk);
        checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== exp || o_error !== 1'b0) begin
            errors++;
            $display("FAIL %s send: tx_start=%b tx_data=%h error=%b, required 1 %h 0", name, o_tx_start, o_tx_data, exp, o_error);
        end
        @(negedge i_clk);
        checks++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_tx: tx_start=%b busy=%b, required 0 1", name, o_tx_start, o_busy);
        end
        pulse_tx_done();
        checks++;
        if (o_busy !== 1'b0 || o_tx_data !== exp) begin
            errors++;
            $display("FAIL %s done: busy=%b tx_data=%h, required 0 %h", name, o_busy, o_tx_data, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_error} !== '0) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h op=%h tx=%h start=%b busy=%b err=%b, required all 0",
                     o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_error);
        end
    endtask

    task automatic test_ops();
        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        run_frame("xor", 8'hF0, 8'h3C, 8'h26, 8'hCC);
        run_frame("sub_wrap", 8'h02, 8'h05, 8'h22, 8'hFD);
        run_frame("nor", 8'h0F, 8'hF0, 8'h27, 8'h00);
        run_frame("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
        run_frame("srl", 8'h80, 8'h03, 8'h02, 8'h10);
        run_frame("op_upper_bits", 8'h0C, 8'h0A, 8'hE4, 8'h08);
    endtask

    task automatic test_bad_opcode();
        run_frame("pre_bad", 8'h05, 8'h03, 8'h20, 8'h08);
        send_word(8'h05);
        send_word(8'h03);
        send_word(8'h3F);
        @(negedge i_clk);
        checks++;
        if (o_error !== 1'b1 || o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_tx_data !== 8'h08) begin
            errors++;
            $display("FAIL bad_op: error=%b busy=%b start=%b tx=%h, required 1 0 0 08", o_error, o_busy, o_tx_start, o_tx_data);
        end
        @(negedge i_clk);
        checks++;
        if (o_error !== 1'b0 || o_tx_start !== 1'b0) begin
            errors++;
            $display("FAIL bad_op_after: error=%b start=%b, required 0 0", o_error, o_tx_start);
        end
    endtask

    task automatic test_overrun();
        send_word(8'h0C);
        send_word(8'h0A);
        send_word(8'h25);
        @(negedge i_clk);
        @(negedge i_clk);
        send_word(8'hAA);
        checks++;
        if (o_error !== 1'b1 || o_busy !== 1'b1 || o_alu_a !== 8'h0C || o_tx_data !== 8'h0E) begin
            errors++;
            $display("FAIL overrun: error=%b busy=%b a=%h tx=%h, required 1 1 0c 0e", o_error, o_busy, o_alu_a, o_tx_data);
        end
        @(negedge i_clk);
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_after: error=%b busy=%b, required 0 1", o_error, o_busy);
        end
        pulse_tx_done();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_release: busy=%b, required 0", o_busy);
        end
        run_frame("after_overrun", 8'h0F, 8'h01, 8'h22, 8'h0E);
    endtask

    task automatic test_rx_tx_same_cycle();
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h20);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rx_done = 1'b1;
        i_rx_data = 8'h77;
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        checks++;
        if (o_error !== 1'b1 || o_busy !== 1'b0 || o_alu_a !== 8'h01) begin
            errors++;
            $display("FAIL rx_tx_same: error=%b busy=%b a=%h, required 1 0 01", o_error, o_busy, o_alu_a);
        end
        run_frame("after_same", 8'h30, 8'h03, 8'h24, 8'h00);
    endtask

    task automatic test_reset_mid_frame();
        send_word(8'h11);
        send_word(8'h22);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        checks++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_error} !== '0) begin
            errors++;
            $display("FAIL reset_mid: a=%h b=%h op=%h tx=%h start=%b busy=%b err=%b, required all 0",
                     o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_error);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        run_frame("after_reset", 8'h05, 8'h03, 8'h20, 8'h08);
    endtask

    task automatic test_tx_done_idle();
        pulse_tx_done();
        checks++;
        if (o_busy !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL tx_done_idle: busy=%b error=%b, required 0 0", o_busy, o_error);
        end
        run_frame("after_idle_tx", 8'h40, 8'h04, 8'h25, 8'h44);
    endtask

    task automatic test_timeout();
        int seen;
        seen = -1;
        send_word(8'h01);
        for (int i = 1; i <= 150; i++) begin
            @(negedge i_clk);
            if (o_error === 1'b1 && seen < 0) seen = i;
        end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        checks++;
        if (seen !== 100 || o_busy !== 1'b0 || o_alu_a !== 8'h01) begin
            errors++;
            $display("FAIL timeout: error_cycle=%0d busy=%b a=%h, required 100 0 01", seen, o_busy, o_alu_a);
        end
`else
        checks++;
        if (seen !== -1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: error_cycle=%0d busy=%b, required -1 1", seen, o_busy);
        end
        do_reset();
`endif
        run_frame("after_timeout", 8'h09, 8'h01, 8'h20, 8'h0A);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_bad_opcode();
        test_overrun();
        test_rx_tx_same_cycle();
        test_reset_mid_frame();
        test_tx_done_idle();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: operand, result and UART word width.
REQ-002 The block SHALL have parameter OP_BITS, default 6: ALU opcode width, taken from the LSBs of the opcode word.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 5_208_000: mid-frame inactivity limit in i_clk cycles.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high, ports i_clk and i_reset.
REQ-005 The block SHALL have these ports:
- i_clk  in  1  system clock
- i_reset  in  1  async active-high reset
- i_rx_done  in  1  one-cycle pulse, received word valid
- i_rx_data  in  DATA_BITS  received word
- i_tx_done  in  1  one-cycle pulse, transmitter finished
- i_alu_result  in  DATA_BITS  combinational ALU result
- o_alu_a  out  DATA_BITS  operand A register
- o_alu_b  out  DATA_BITS  operand B register
- o_alu_op  out  OP_BITS  opcode register
- o_tx_start  out  1  one-cycle transmit request
- o_tx_data  out  DATA_BITS  word to transmit
- o_busy  out  1  high in every state except IDLE
- o_error  out  1  one-cycle pulse: bad opcode, overrun or timeout

Function
REQ-006 The FSM SHALL have the states IDLE, GET_B, GET_OP, EXEC, SEND and WAIT_TX.
REQ-007 In IDLE, an i_rx_done pulse SHALL load i_rx_data into o_alu_a and move the FSM to GET_B.
REQ-008 In GET_B, an i_rx_done pulse SHALL load o_alu_b and move the FSM to GET_OP.
REQ-009 In GET_OP, an i_rx_done pulse SHALL load o_alu_op from i_rx_data[OP_BITS-1:0] and move the FSM to EXEC.
REQ-010 In EXEC (one cycle), a valid opcode SHALL latch i_alu_result into o_tx_data and move the FSM to SEND.
REQ-011 In EXEC, an invalid opcode SHALL pulse o_error, leave o_tx_data unchanged and return the FSM to IDLE.
REQ-012 SEND SHALL assert o_tx_start for exactly one cycle and then move the FSM to WAIT_TX.
REQ-013 In WAIT_TX, i_tx_done SHALL return the FSM to IDLE.
REQ-014 Latency SHALL be fixed: o_tx_start goes high exactly 2 cycles after the i_rx_done of the opcode word.
REQ-015 An i_rx_done pulse in EXEC, SEND or WAIT_TX SHALL be discarded with a one-cycle o_error pulse (overrun), and the current state SHALL NOT change.
REQ-016 An i_tx_done pulse outside WAIT_TX SHALL be ignored.
REQ-017 When i_rx_done and i_tx_done are high in the same cycle in WAIT_TX, the FSM SHALL go to IDLE, drop the word and pulse o_error.
REQ-018 Valid opcodes SHALL be ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011 and SRL 000010; all other codes SHALL be invalid.

Reset
REQ-019 Asserting i_reset SHALL force the FSM to IDLE and clear all outputs to 0 (o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_error), including mid-frame and mid-transmit.
REQ-020 After reset, the first i_rx_done SHALL be treated as operand A.

Configuration
REQ-021 With UART_ALU_CTRL_TIMEOUT_EN defined, a counter SHALL run in GET_B and GET_OP and clear on every i_rx_done.
REQ-022 With UART_ALU_CTRL_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES-1 SHALL pulse o_error and return the FSM to IDLE, leaving the operand registers unchanged.
REQ-023 Without UART_ALU_CTRL_TIMEOUT_EN, the counter SHALL NOT be instantiated, the FSM SHALL wait indefinitely for the next word, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-024 The package uart_alu_pkg SHALL hold the opcode localparams, the FSM state enum and the default widths.
REQ-025 The timeout counter SHALL be the sub-module uart_alu_timeout, with a clear input, an enable input and an expired pulse output.

Verification
REQ-026 The bench SHALL send A=0x05, B=0x03, OP=0x20 with a model ALU -> one o_tx_start with o_tx_data=0x08, 2 cycles after the OP rx_done.
REQ-027 The bench SHALL send A=0x05, B=0x03, OP=0x3F -> one o_error pulse, no o_tx_start, o_busy low one cycle after EXEC.
REQ-028 The bench SHALL send a valid frame and pulse i_rx_done=0xAA during WAIT_TX -> one o_error pulse; after i_tx_done, the next frame A=0x0F, B=0x01, OP=0x22 gives o_tx_data=0x0E.
REQ-029 The bench SHALL assert i_reset while in GET_OP after A=0x11, B=0x22 -> all outputs 0; a fresh frame then computes correctly.
REQ-030 With UART_ALU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, the bench SHALL send only A=0x01 -> o_error pulse at cycle 100 after that rx_done, FSM in IDLE; without the macro, o_busy stays high.
REQ-031 The bench SHALL pulse i_tx_done while in IDLE -> no state change and no o_error.
